multicycle_control: RTL and testbench
=====================================

# multicycle_control

Main control FSM for the multicycle MIPS core. Sequences every instruction through fetch, decode, execute, memory and writeback. Drives the PC block's `pc_write` and `branch` enables, the instruction register, register file, ALU muxes and a single shared instruction/data memory port, with a ready handshake. One instance per core, sitting beside the datapath (PC, IR, register file, ALU, ALUOut, MDR).

## Interface
- No parameters; the opcode set and state encoding are fixed.
- `clk  in  1`: rising-edge clock; the only clock.
- `reset  in  1`: synchronous, active-high reset.
- `opcode  in  6`: IR[31:26]; sampled only in DECODE.
- `zero  in  1`: ALU zero flag; forwarded by the PC block, not used here.
- `mem_ready  in  1`: memory completes the current access this cycle.
- `mem_req  out  1`: memory access request; held until `mem_ready`.
- `mem_write  out  1`: 1 = write access, 0 = read.
- `iord  out  1`: address mux select; 0 = PC, 1 = ALUOut.
- `ir_write  out  1`: IR load enable.
- `pc_write  out  1`: unconditional PC load (to the PC block).
- `branch  out  1`: conditional PC load (to the PC block's `branch`; PC block ANDs it with `zero`).
- `pc_source  out  2`: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alu_src_a  out  1`: 0 = PC, 1 = reg A.
- `alu_src_b  out  2`: 00 = reg B, 01 = const 4, 10 = sign-extended imm, 11 = imm<<2.
- `alu_op  out  2`: 00 = add, 01 = sub, 10 = funct decode.
- `reg_write  out  1`: register file write enable.
- `reg_dst  out  1`: 0 = rt, 1 = rd.
- `mem_to_reg  out  1`: 0 = ALUOut, 1 = MDR.
- `illegal_op  out  1`: one-cycle pulse on an unsupported opcode.
- `state  out  4`: current state code, for debug.

## Operation
State codes:
- 0 FETCH
- 1 DECODE
- 2 MEMADR
- 3 MEMRD
- 4 MEMWB
- 5 MEMWR
- 6 EXEC
- 7 ALUWB
- 8 BRANCH
- 9 ADDIEX
- 10 ADDIWB
- 11 JUMP
- 12–15 unused; go to FETCH on the next edge.

Transitions:
- FETCH → DECODE when `mem_ready`; otherwise stay in FETCH.
- DECODE dispatches on `opcode`:
  - 100011 (lw) or 101011 (sw) → MEMADR.
  - 000000 (R-type) → EXEC.
  - 000100 (beq) → BRANCH.
  - 001000 (addi) → ADDIEX.
  - 000010 (j) → JUMP.
  - Anything else → FETCH with `illegal_op`=1; the instruction is executed as a nop.
- MEMADR → MEMRD for lw, → MEMWR for sw. The opcode is latched in DECODE.
- MEMRD → MEMWB on `mem_ready`; otherwise stay.
- MEMWR → FETCH on `mem_ready`; otherwise stay.
- MEMWB, ALUWB, ADDIWB, BRANCH and JUMP → FETCH.
- EXEC → ALUWB. ADDIEX → ADDIWB.

Moore outputs per state (any output not listed is 0):
- FETCH: `mem_req`=1, `iord`=0, `alu_src_a`=0, `alu_src_b`=01, `alu_op`=00, `pc_source`=00. `ir_write`=`pc_write`=`mem_ready`, so the PC does not advance during wait states.
- DECODE: `alu_src_a`=0, `alu_src_b`=11, `alu_op`=00. Branch target goes to ALUOut.
- MEMADR, ADDIEX: `alu_src_a`=1, `alu_src_b`=10, `alu_op`=00.
- MEMRD: `mem_req`=1, `iord`=1.
- MEMWR: `mem_req`=1, `iord`=1, `mem_write`=1.
- MEMWB: `reg_write`=1, `mem_to_reg`=1, `reg_dst`=0.
- EXEC: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=10.
- ALUWB: `reg_write`=1, `reg_dst`=1.
- ADDIWB: `reg_write`=1, `reg_dst`=0.
- BRANCH: `alu_src_a`=1, `alu_src_b`=00, `alu_op`=01, `branch`=1, `pc_source`=01.
- JUMP: `pc_write`=1, `pc_source`=10.

Rules:
- `mem_req` never deasserts before `mem_ready` is seen.
- `mem_write` and `iord` are stable for the whole request.

## Timing
- `reset` high at an edge → `state`=FETCH, latched opcode cleared.
- While `reset`=1, combinationally force to 0: `mem_req`, `mem_write`, `ir_write`, `pc_write`, `branch`, `reg_write`, `illegal_op`.
- First cycle after reset deasserts: FETCH outputs as listed.
- Reset mid-instruction (including during a wait state) aborts the instruction. No register or memory write occurs in that cycle.
- Cycles per instruction with zero-wait memory (`mem_ready`=1 whenever `mem_req`=1):
  - lw 5; sw 4; R-type 4; addi 4; beq 3; j 3; illegal 2.
- Each memory wait cycle adds exactly one cycle to the state holding `mem_req`.
- `mem_ready` is ignored when `mem_req`=0.
- `illegal_op` is high only in the DECODE cycle.

## Test plan
- Reset held 2 cycles, `mem_ready`=1 → during reset all enables are 0. Then `state`=0, `mem_req`=1, `alu_src_b`=01. Next edge `state`=1.
- lw (opcode 100011), `mem_ready`=1 → states 0,1,2,3,4,0. `reg_write`=1 with `mem_to_reg`=1 only in state 4. `iord`=1 only in state 3.
- sw with `mem_ready` low for 3 cycles in MEMWR → `state` holds 5 for 4 cycles with `mem_write`=1 and `mem_req`=1 throughout, then returns to 0. `reg_write` never asserts.
- Sequence R-type, addi, beq, j, each with `mem_ready`=1 → cycle counts 4,4,3,3. `branch`=1 with `pc_source`=01 only in BRANCH. `pc_write`=1 with `pc_source`=10 only in JUMP.
- FETCH with `mem_ready` low for 2 cycles → `pc_write` and `ir_write` stay 0 for 2 cycles, then pulse for exactly 1 cycle.
- Opcode 111111 → `illegal_op` pulses in DECODE, next state 0. Separately, reset asserted while in state 3 → next state 0 with no `reg_write`.

Source files
------------

// File: rtl/multicycle_control.sv
// Main control FSM of the multicycle MIPS core: fetch/decode/execute/memory/writeback sequencing.
// Moore outputs; only FETCH's ir_write/pc_write follow mem_ready so the PC holds during wait states.
module multicycle_control (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       mem_req,
    output logic       mem_write,
    output logic       iord,
    output logic       ir_write,
    output logic       pc_write,
    output logic       branch,
    output logic [1:0] pc_source,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXEC   = 4'd6,
        S_ALUWB  = 4'd7,
        S_BRANCH = 4'd8,
        S_ADDIEX = 4'd9,
        S_ADDIWB = 4'd10,
        S_JUMP   = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;

    state_t     state_q, state_d;
    logic [5:0] op_q, op_d;

    // The PC block consumes zero together with branch; nothing here needs it.
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH;
            op_q    <= 6'd0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d = S_FETCH;
        op_d    = op_q;
        case (state_q)
            S_FETCH:  state_d = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: begin
                op_d = opcode;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_EXEC;
                    OP_BEQ:       state_d = S_BRANCH;
                    OP_ADDI:      state_d = S_ADDIEX;
                    OP_J:         state_d = S_JUMP;
                    default:      state_d = S_FETCH;
                endcase
            end
            S_MEMADR: state_d = (op_q == OP_SW) ? S_MEMWR : S_MEMRD;
            S_MEMRD:  state_d = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  state_d = mem_ready ? S_FETCH : S_MEMWR;
            S_EXEC:   state_d = S_ALUWB;
            S_ADDIEX: state_d = S_ADDIWB;
            default:  state_d = S_FETCH;
        endcase
    end

    always_comb begin
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        iord       = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        branch     = 1'b0;
        pc_source  = 2'b00;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req   = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                case (opcode)
                    OP_LW, OP_SW, OP_RTYPE, OP_BEQ, OP_ADDI, OP_J: illegal_op = 1'b0;
                    default:                                       illegal_op = 1'b1;
                endcase
            end
            S_MEMADR, S_ADDIEX: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEMRD: begin
                mem_req = 1'b1;
                iord    = 1'b1;
            end
            S_MEMWR: begin
                mem_req   = 1'b1;
                iord      = 1'b1;
                mem_write = 1'b1;
            end
            S_MEMWB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_EXEC: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b10;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_ADDIWB: reg_write = 1'b1;
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 2'b01;
                branch    = 1'b1;
                pc_source = 2'b01;
            end
            S_JUMP: begin
                pc_write  = 1'b1;
                pc_source = 2'b10;
            end
            default: ;
        endcase
        // Reset aborts the cycle: no side-effecting enable may leak out.
        if (reset) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            branch     = 1'b0;
            reg_write  = 1'b0;
            illegal_op = 1'b0;
        end
    end

    assign state = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control: reset, lw/sw with waits, CPI of each class, illegal opcode, reset abort.
module tb_multicycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       mem_req, mem_write, iord, ir_write, pc_write, branch;
    logic [1:0] pc_source, alu_src_b, alu_op;
    logic       alu_src_a, reg_write, reg_dst, mem_to_reg, illegal_op;
    logic [3:0] state;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    multicycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .opcode     (opcode),
        .zero       (zero),
        .mem_ready  (mem_ready),
        .mem_req    (mem_req),
        .mem_write  (mem_write),
        .iord       (iord),
        .ir_write   (ir_write),
        .pc_write   (pc_write),
        .branch     (branch),
        .pc_source  (pc_source),
        .alu_src_a  (alu_src_a),
        .alu_src_b  (alu_src_b),
        .alu_op     (alu_op),
        .reg_write  (reg_write),
        .reg_dst    (reg_dst),
        .mem_to_reg (mem_to_reg),
        .illegal_op (illegal_op),
        .state      (state)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge, then apply mem_ready and let outputs settle before checking.
    task automatic tick(input logic mr);
        @(posedge clk);
        #1;
        mem_ready = mr;
        #1;
    endtask

    // Runs one instruction from FETCH with zero-wait memory; returns cycles until FETCH again.
    task automatic run_instr(input string tag, input logic [5:0] op, output int cnt);
        opcode = op;
        cnt = 1;
        tick(1'b1);
        while (state != 4'd0 && cnt < 20) begin
            check({tag, "_br"}, {31'd0, branch && pc_source == 2'b01}, {31'd0, state == 4'd8});
            check({tag, "_jmp"}, {31'd0, pc_write && pc_source == 2'b10}, {31'd0, state == 4'd11});
            check({tag, "_rw"}, {31'd0, reg_write},
                  {31'd0, state == 4'd4 || state == 4'd7 || state == 4'd10});
            tick(1'b1);
            cnt++;
        end
    endtask

    initial begin
        int cnt;
        reset = 1'b1;
        mem_ready = 1'b1;
        opcode = 6'b100011;
        zero = 1'b0;

        // Reset held two edges with mem_ready high: all enables stay off
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #2;
            check("rst_state", {28'd0, state}, 32'd0);
            check("rst_enables", {25'd0, mem_req, mem_write, ir_write, pc_write, branch, reg_write, illegal_op}, 32'd0);
        end
        #1;
        reset = 1'b0;
        #1;
        check("fetch_state", {28'd0, state}, 32'd0);
        check("fetch_req", {31'd0, mem_req}, 32'd1);
        check("fetch_srcb", {30'd0, alu_src_b}, 32'd1);
        check("fetch_pcw", {31'd0, pc_write}, 32'd1);

        // lw: 0,1,2,3,4,0
        tick(1'b1);
        check("lw_s1", {28'd0, state}, 32'd1);
        check("lw_s1_srcb", {30'd0, alu_src_b}, 32'd3);
        tick(1'b1);
        check("lw_s2", {28'd0, state}, 32'd2);
        check("lw_s2_alu", {27'd0, alu_src_a, alu_src_b, iord, reg_write}, 32'b1_10_0_0);
        tick(1'b1);
        check("lw_s3", {28'd0, state}, 32'd3);
        check("lw_s3_mem", {28'd0, mem_req, iord, mem_write, reg_write}, 32'b1100);
        tick(1'b1);
        check("lw_s4", {28'd0, state}, 32'd4);
        check("lw_s4_wb", {27'd0, reg_write, mem_to_reg, reg_dst, iord, mem_req}, 32'b11000);
        tick(1'b1);
        check("lw_done", {28'd0, state}, 32'd0);

        // sw with three wait cycles in MEMWR
        opcode = 6'b101011;
        tick(1'b1);
        check("sw_s1", {28'd0, state}, 32'd1);
        tick(1'b1);
        check("sw_s2", {28'd0, state}, 32'd2);
        for (int i = 0; i < 4; i++) begin
            tick(i == 3);
            check("sw_wr_state", {28'd0, state}, 32'd5);
            check("sw_wr_out", {28'd0, mem_req, mem_write, iord, reg_write}, 32'b1110);
        end
        tick(1'b1);
        check("sw_done", {28'd0, state}, 32'd0);
        check("sw_done_rw", {31'd0, reg_write}, 32'd0);

        run_instr("rtype", 6'b000000, cnt);
        check("rtype_cpi", cnt, 32'd4);
        run_instr("addi", 6'b001000, cnt);
        check("addi_cpi", cnt, 32'd4);
        run_instr("beq", 6'b000100, cnt);
        check("beq_cpi", cnt, 32'd3);
        run_instr("j", 6'b000010, cnt);
        check("j_cpi", cnt, 32'd3);

        // FETCH held two wait cycles, then an illegal opcode
        opcode = 6'b111111;
        mem_ready = 1'b0;
        #1;
        check("fw_w1", {30'd0, pc_write, ir_write}, 32'd0);
        tick(1'b0);
        check("fw_w2", {30'd0, pc_write, ir_write}, 32'd0);
        check("fw_w2_state", {28'd0, state}, 32'd0);
        tick(1'b1);
        check("fw_pulse", {30'd0, pc_write, ir_write}, 32'd3);
        tick(1'b1);
        check("ill_state", {28'd0, state}, 32'd1);
        check("ill_pulse", {31'd0, illegal_op}, 32'd1);
        check("ill_pcw", {30'd0, pc_write, ir_write}, 32'd0);
        tick(1'b1);
        check("ill_next", {28'd0, state}, 32'd0);
        check("ill_clear", {31'd0, illegal_op}, 32'd0);

        // Reset while MEMRD is waiting on memory
        opcode = 6'b100011;
        tick(1'b1);
        tick(1'b1);
        tick(1'b0);
        check("ab_state", {28'd0, state}, 32'd3);
        reset = 1'b1;
        #1;
        check("ab_gate", {29'd0, mem_req, reg_write, mem_write}, 32'd0);
        tick(1'b1);
        check("ab_state0", {28'd0, state}, 32'd0);
        check("ab_rw", {31'd0, reg_write}, 32'd0);
        reset = 1'b0;
        #1;
        check("ab_fetch", {31'd0, mem_req}, 32'd1);
        tick(1'b1);
        check("ab_decode", {28'd0, state}, 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
